// File: rtl/seg7_pkg.sv
// Shared encodings for the seven-segment display driver.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000,   // 0
        7'b1111001,   // 1
        7'b0100100,   // 2
        7'b0110000,   // 3
        7'b0011001,   // 4
        7'b0010010,   // 5
        7'b0000010,   // 6
        7'b1111000,   // 7
        7'b0000000,   // 8
        7'b0010000,   // 9
        7'b0001000,   // A
        7'b0000011,   // b
        7'b1000110,   // C
        7'b0100001,   // d
        7'b0000110,   // E
        7'b0001110    // F
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nybble to active-low seven-segment pattern decoder.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nybble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_HEX[nybble];

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed common-anode seven-segment driver with per-frame input
// snapshot, leading-zero blanking, per-digit blink and 16-level PWM brightness.
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_LOG2  = 17,
    parameter int BLINK_LOG2 = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS*4-1:0] number,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_en,
    input  logic [3:0]              brightness,
    input  logic                    enable,
    output logic [NUM_DIGITS-1:0]   io_sel,
    output logic [7:0]              io_seg
);

    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [SLOT_LOG2-1:0]    tick_q, tick_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BLINK_LOG2-1:0]   blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [NUM_DIGITS*4-1:0] num_sh_q, num_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [NUM_DIGITS-1:0]   bm_sh_q, bm_sh_d;
    logic                    lz_sh_q, lz_sh_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [7:0]              seg_q, seg_d;

    logic                    slot_end;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [NUM_DIGITS-1:0]   cur_onehot;
    logic [3:0]              cur_nyb;
    logic                    cur_dp;
    logic                    cur_blink;
    logic                    cur_lz;
    logic [6:0]              cur_pattern;
    logic                    dark;

    assign slot_end  = &tick_q;
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    always_comb begin
        tick_d        = tick_q + SLOT_LOG2'(1);
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        num_sh_d      = num_sh_q;
        dp_sh_d       = dp_sh_q;
        bm_sh_d       = bm_sh_q;
        lz_sh_d       = lz_sh_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        // Inputs only reach the display through this once-per-frame snapshot.
        if (frame_end) begin
            num_sh_d    = number;
            dp_sh_d     = dp_mask;
            bm_sh_d     = blink_mask;
            lz_sh_d     = lz_en;
            blink_cnt_d = blink_cnt_q + BLINK_LOG2'(1);
            if (&blink_cnt_q) begin
                blink_phase_d = ~blink_phase_q;
            end
        end
    end

    always_comb begin : digit_select
        logic zero_above;
        zero_above = 1'b1;
        lz_blank   = '0;
        cur_onehot = '0;
        cur_nyb    = 4'd0;
        cur_dp     = 1'b0;
        cur_blink  = 1'b0;
        cur_lz     = 1'b0;
        // Scan from the most significant digit; digit 0 always stays visible.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above  = zero_above && (num_sh_q[4*i +: 4] == 4'd0);
            lz_blank[i] = lz_sh_q && zero_above && (i != 0);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_onehot[i] = 1'b1;
                cur_nyb       = num_sh_q[4*i +: 4];
                cur_dp        = dp_sh_q[i];
                cur_blink     = bm_sh_q[i];
                cur_lz        = lz_blank[i];
            end
        end
    end

    seg7_decoder u_decoder (
        .nybble (cur_nyb),
        .seg_n  (cur_pattern)
    );

    always_comb begin
        dark = !enable
            || (tick_q[SLOT_LOG2-1 -: 4] > brightness)
            || (cur_blink && blink_phase_q)
            || cur_lz;
        sel_d = dark ? '1 : ~cur_onehot;
        seg_d = dark ? SEG_BLANK : {~cur_dp, cur_pattern};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q        <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            num_sh_q      <= '0;
            dp_sh_q       <= '0;
            bm_sh_q       <= '0;
            lz_sh_q       <= 1'b0;
            sel_q         <= '1;
            seg_q         <= SEG_BLANK;
        end else begin
            tick_q        <= tick_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            num_sh_q      <= num_sh_d;
            dp_sh_q       <= dp_sh_d;
            bm_sh_q       <= bm_sh_d;
            lz_sh_q       <= lz_sh_d;
            sel_q         <= sel_d;
            seg_q         <= seg_d;
        end
    end

    assign io_sel = sel_q;
    assign io_seg = seg_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Self-checking bench for seg7_mux_driver: 4 digits, 16-cycle slots, 64-cycle frames.
module tb_seg7_mux_driver;

    localparam int ND    = 4;
    localparam int SLOT  = 16;
    localparam int FRAME = ND * SLOT;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   number;
    logic [3:0]    dp_mask;
    logic [3:0]    blink_mask;
    logic          lz_en;
    logic [3:0]    brightness;
    logic          enable;
    logic [3:0]    io_sel;
    logic [7:0]    io_seg;

    always #5 clk = ~clk;

    seg7_mux_driver #(
        .NUM_DIGITS (ND),
        .SLOT_LOG2  (4),
        .BLINK_LOG2 (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .number     (number),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .lz_en      (lz_en),
        .brightness (brightness),
        .enable     (enable),
        .io_sel     (io_sel),
        .io_seg     (io_seg)
    );

    typedef struct {
        logic [15:0] number;
        logic [3:0]  dp;
        logic        lz;
        logic [3:0]  bright;
        logic        en;
        int          slot;
        int          tk;
        logic [3:0]  esel;
        logic [7:0]  eseg;
    } vec_t;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] seg;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   edges  = 0;   // non-reset edges since the last reset; output shows position edges-1

    task automatic step();
        @(posedge clk);
        if (rst) edges = 0;
        else     edges++;
        #1;
    endtask

    task automatic next_frame();
        step();
        while ((edges - 1) % FRAME != FRAME - 1) step();
    endtask

    task automatic goto_pos(input int slot, input int tk);
        step();
        while ((edges - 1) % FRAME != slot * SLOT + tk) step();
    endtask

    task automatic push_exp(input logic [3:0] s, input logic [7:0] g);
        exp_t e;
        e.sel = s;
        e.seg = g;
        sb_q.push_back(e);
    endtask

    task automatic check_out(input string name);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expectation queued, got sel=%b seg=%h", name, io_sel, io_seg);
        end else begin
            e = sb_q.pop_front();
            if (io_sel !== e.sel || io_seg !== e.seg) begin
                n_fail++;
                $display("FAIL %s: got sel=%b seg=%h, want sel=%b seg=%h",
                         name, io_sel, io_seg, e.sel, e.seg);
            end
        end
    endtask

    task automatic add_vec(input logic [15:0] num, input logic [3:0] dp, input logic lz,
                           input logic [3:0] br, input logic en, input int slot, input int tk,
                           input logic [3:0] esel, input logic [7:0] eseg);
        vec_t v;
        v.number = num; v.dp = dp; v.lz = lz; v.bright = br; v.en = en;
        v.slot = slot; v.tk = tk; v.esel = esel; v.eseg = eseg;
        vecs.push_back(v);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        // number, dp, lz, bright, en, slot, tick, expected sel, expected seg
        add_vec(16'h1234, 4'h0, 1'b0, 4'd15, 1'b1, 0,  0, 4'hE, 8'h99);
        add_vec(16'h1234, 4'h0, 1'b0, 4'd15, 1'b1, 3,  5, 4'h7, 8'hF9);
        add_vec(16'h1234, 4'h0, 1'b0, 4'd15, 1'b1, 1, 15, 4'hD, 8'hB0);
        add_vec(16'h1234, 4'h0, 1'b0, 4'd15, 1'b1, 2,  8, 4'hB, 8'hA4);
        add_vec(16'h0042, 4'h0, 1'b1, 4'd15, 1'b1, 3,  0, 4'hF, 8'hFF);
        add_vec(16'h0042, 4'h0, 1'b1, 4'd15, 1'b1, 2,  3, 4'hF, 8'hFF);
        add_vec(16'h0042, 4'h0, 1'b1, 4'd15, 1'b1, 1,  0, 4'hD, 8'h99);
        add_vec(16'h0042, 4'h0, 1'b1, 4'd15, 1'b1, 0,  0, 4'hE, 8'hA4);
        add_vec(16'h0000, 4'h0, 1'b1, 4'd15, 1'b1, 0,  0, 4'hE, 8'hC0);
        add_vec(16'h0000, 4'h0, 1'b1, 4'd15, 1'b1, 1,  0, 4'hF, 8'hFF);
        add_vec(16'h0000, 4'h0, 1'b0, 4'd15, 1'b1, 3,  0, 4'h7, 8'hC0);
        add_vec(16'h5678, 4'h4, 1'b0, 4'd15, 1'b1, 2,  0, 4'hB, 8'h02);
        add_vec(16'h5678, 4'h4, 1'b0, 4'd15, 1'b1, 1,  0, 4'hD, 8'hF8);
        add_vec(16'h5678, 4'h4, 1'b0, 4'd15, 1'b1, 0,  0, 4'hE, 8'h80);
        add_vec(16'h5678, 4'h4, 1'b0, 4'd15, 1'b1, 3,  0, 4'h7, 8'h92);
        add_vec(16'h0402, 4'h0, 1'b1, 4'd15, 1'b1, 1,  0, 4'hD, 8'hC0);
        add_vec(16'h0402, 4'h0, 1'b1, 4'd15, 1'b1, 3,  0, 4'hF, 8'hFF);
        add_vec(16'h0402, 4'h0, 1'b1, 4'd15, 1'b1, 2,  0, 4'hB, 8'h99);
        add_vec(16'h9000, 4'h0, 1'b1, 4'd15, 1'b1, 3,  0, 4'h7, 8'h90);
        add_vec(16'h9000, 4'h0, 1'b1, 4'd15, 1'b1, 0,  0, 4'hE, 8'hC0);
        add_vec(16'hABCD, 4'h0, 1'b0, 4'd15, 1'b1, 3,  0, 4'h7, 8'h88);
        add_vec(16'hABCD, 4'h0, 1'b0, 4'd15, 1'b1, 2,  0, 4'hB, 8'h83);
        add_vec(16'hABCD, 4'h0, 1'b0, 4'd15, 1'b1, 1,  0, 4'hD, 8'hC6);
        add_vec(16'hABCD, 4'h0, 1'b0, 4'd15, 1'b1, 0,  0, 4'hE, 8'hA1);
        add_vec(16'hEF00, 4'h0, 1'b0, 4'd15, 1'b1, 3,  0, 4'h7, 8'h86);
        add_vec(16'hEF00, 4'h0, 1'b0, 4'd15, 1'b1, 2,  0, 4'hB, 8'h8E);
        add_vec(16'h1234, 4'h0, 1'b0, 4'd3,  1'b1, 0,  3, 4'hE, 8'h99);
        add_vec(16'h1234, 4'h0, 1'b0, 4'd3,  1'b1, 0,  4, 4'hF, 8'hFF);
        add_vec(16'h1234, 4'h0, 1'b0, 4'd3,  1'b1, 2, 15, 4'hF, 8'hFF);
        add_vec(16'h1234, 4'h0, 1'b0, 4'd0,  1'b1, 0,  0, 4'hE, 8'h99);
        add_vec(16'h1234, 4'h0, 1'b0, 4'd0,  1'b1, 0,  1, 4'hF, 8'hFF);
        add_vec(16'h1234, 4'h0, 1'b0, 4'd15, 1'b0, 0,  0, 4'hF, 8'hFF);

        // Reset: dark during reset, frame 0 shows the cleared snapshot.
        rst = 1'b1; number = 16'h1234; dp_mask = 4'h0; blink_mask = 4'h0;
        lz_en = 1'b0; brightness = 4'd15; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            push_exp(4'hF, 8'hFF);
            check_out($sformatf("reset_hold%0d", i));
        end
        rst = 1'b0;
        step();
        push_exp(4'hE, 8'hC0); check_out("frame0_slot0");
        goto_pos(3, 0);
        push_exp(4'h7, 8'hC0); check_out("frame0_slot3");
        next_frame();
        goto_pos(0, 0);
        push_exp(4'hE, 8'h99); check_out("frame1_slot0");
        goto_pos(3, 0);
        push_exp(4'h7, 8'hF9); check_out("frame1_slot3");

        for (int k = 0; k < vecs.size(); k++) begin
            number = vecs[k].number; dp_mask = vecs[k].dp; lz_en = vecs[k].lz;
            brightness = vecs[k].bright; enable = vecs[k].en; blink_mask = 4'h0;
            push_exp(vecs[k].esel, vecs[k].eseg);
            next_frame();
            goto_pos(vecs[k].slot, vecs[k].tk);
            check_out($sformatf("vec%0d", k));
        end

        // PWM duty: brightness 3 lights exactly the first 4 ticks of a slot.
        number = 16'h1234; dp_mask = 4'h0; lz_en = 1'b0; enable = 1'b1; brightness = 4'd3;
        next_frame();
        goto_pos(0, 0);
        for (int t = 0; t < SLOT; t++) begin
            if (t < 4) push_exp(4'hE, 8'h99);
            else       push_exp(4'hF, 8'hFF);
            check_out($sformatf("pwm3_t%0d", t));
            if (t < SLOT - 1) step();
        end
        brightness = 4'd15;

        // Snapshot: a mid-frame change does not tear the current frame.
        number = 16'h1111;
        next_frame();
        goto_pos(1, 2);
        push_exp(4'hD, 8'hF9); check_out("tear_before");
        number = 16'h2222;
        goto_pos(2, 0);
        push_exp(4'hB, 8'hF9); check_out("tear_slot2");
        goto_pos(3, 0);
        push_exp(4'h7, 8'hF9); check_out("tear_slot3");
        goto_pos(0, 0);
        push_exp(4'hE, 8'hA4); check_out("tear_next0");
        goto_pos(1, 0);
        push_exp(4'hD, 8'hA4); check_out("tear_next1");

        // Blink: phase flips every 2 frames counted from reset release.
        number = 16'h1111; blink_mask = 4'b0001;
        next_frame();
        for (int i = 0; i < 8; i++) begin
            goto_pos(0, 0);
            f = (edges - 1) / FRAME;
            if (((f / 2) % 2) == 1) push_exp(4'hF, 8'hFF);
            else                    push_exp(4'hE, 8'hF9);
            check_out($sformatf("blink_f%0d_d0", f));
            goto_pos(1, 0);
            push_exp(4'hD, 8'hF9);
            check_out($sformatf("blink_f%0d_d1", f));
        end

        // Mid-frame reset: dark on the next edge, then restart from cleared state.
        blink_mask = 4'h0;
        next_frame();
        goto_pos(2, 5);
        push_exp(4'hB, 8'hF9); check_out("midrst_before");
        rst = 1'b1;
        step();
        push_exp(4'hF, 8'hFF); check_out("midrst_dark");
        rst = 1'b0;
        step();
        push_exp(4'hE, 8'hC0); check_out("midrst_slot0");
        goto_pos(1, 0);
        push_exp(4'hD, 8'hC0); check_out("midrst_slot1");
        next_frame();
        goto_pos(0, 0);
        push_exp(4'hE, 8'hF9); check_out("midrst_frame1");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
